cast_rt_loader: RTL and testbench

CAST_RT_LOADER -- requirements
Module: cast_rt_loader

---
 rtl/cast_rt_loader_if.sv | 31 +++
 rtl/cast_rt_loader.sv | 195 +++++++++++++++++++
 tb/tb_cast_rt_loader.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cast_rt_loader_if.sv
// Config-stream and route-table-write bundle for the multicast route-table loader.
// The master side feeds config words and observes writes/status; the slave side
// is the loader itself.
interface cast_rt_loader_if #(
   parameter int CN    = 5,
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic              cfg_valid;
   logic              cfg_ready;
   logic [15:0]       cfg_data;
   logic              cfg_last;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [10+CN-1:0]  wr_data;
   logic              busy;
   logic              done;
   logic              err;
   logic [AW:0]       entry_count;

   modport master (
      output cfg_valid, cfg_data, cfg_last,
      input  cfg_ready, wr_en, wr_addr, wr_data, busy, done, err, entry_count
   );

   modport slave (
      input  cfg_valid, cfg_data, cfg_last,
      output cfg_ready, wr_en, wr_addr, wr_data, busy, done, err, entry_count
   );
endinterface

// File: rtl/cast_rt_loader.sv
// Multicast route-table loader: parses config packets (LOAD / CLEAR / illegal)
// arriving as 16-bit words and issues registered route-table writes of
// {candidate mask, stream_id}. Errors are sticky until the next header.
module cast_rt_loader #(
   parameter int CN    = 5,
   parameter int DEPTH = 16
) (
   input logic               clk,
   input logic               rst,
   cast_rt_loader_if.slave   bus
);
   localparam int              AW        = $clog2(DEPTH);
   localparam int              EW        = 10 + CN;
   localparam logic [AW:0]     FULL      = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [9:0]      RSVD_ID   = 10'h3FF;
   localparam logic [3:0]      OP_LOAD   = 4'hA;
   localparam logic [3:0]      OP_CLEAR  = 4'hC;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_ID,
      LOAD_MASK,
      CLEAR,
      DRAIN
   } state_t;

   state_t          state, state_nxt;
   logic            wr_en_r, wr_en_nxt;
   logic [AW-1:0]   wr_addr_r, wr_addr_nxt;
   logic [EW-1:0]   wr_data_r, wr_data_nxt;
   logic            done_r, done_nxt;
   logic            err_r, err_nxt;
   logic [AW:0]     cnt_r, cnt_nxt;
   logic [AW-1:0]   clr_addr, clr_nxt;
   logic            skip, skip_nxt;
   logic [9:0]      pend_id, id_nxt;

   logic            cfg_ready;
   logic            xfer;
   logic [3:0]      opcode;
   logic            last;
   logic            unused_hdr;

   function automatic logic [EW-1:0] pack_entry(input logic [CN-1:0] mask,
                                                input logic [9:0]    id);
      return {mask, id};
   endfunction

   // The loader takes words everywhere except while sweeping the table.
   assign cfg_ready  = !rst && (state != CLEAR);
   assign xfer       = bus.cfg_valid && cfg_ready;
   assign opcode     = bus.cfg_data[15:12];
   assign last       = bus.cfg_last;
   assign unused_hdr = ^bus.cfg_data[11:10];

   assign bus.cfg_ready   = cfg_ready;
   assign bus.wr_en       = wr_en_r;
   assign bus.wr_addr     = wr_addr_r;
   assign bus.wr_data     = wr_data_r;
   assign bus.done        = done_r;
   assign bus.err         = err_r;
   assign bus.entry_count = cnt_r;
   assign bus.busy        = (state != IDLE);

   // Next-state and next-output decode for the packet parser.
   always_comb begin
      state_nxt   = state;
      wr_en_nxt   = 1'b0;
      wr_addr_nxt = wr_addr_r;
      wr_data_nxt = wr_data_r;
      done_nxt    = 1'b0;
      err_nxt     = err_r;
      cnt_nxt     = cnt_r;
      clr_nxt     = clr_addr;
      skip_nxt    = skip;
      id_nxt      = pend_id;

      case (state)
         IDLE: begin
            if (xfer) begin
               if (opcode == OP_LOAD) begin
                  err_nxt = 1'b0;
                  cnt_nxt = '0;
                  if (last) begin
                     done_nxt = 1'b1;
                  end else begin
                     state_nxt = LOAD_ID;
                  end
               end else if (opcode == OP_CLEAR) begin
                  err_nxt   = 1'b0;
                  clr_nxt   = '0;
                  state_nxt = CLEAR;
               end else begin
                  err_nxt = 1'b1;
                  if (!last) begin
                     state_nxt = DRAIN;
                  end
               end
            end
         end

         LOAD_ID: begin
            if (xfer) begin
               if (cnt_r == FULL) begin
                  // Table already full: refuse the entry and flush the rest.
                  err_nxt   = 1'b1;
                  state_nxt = last ? IDLE : DRAIN;
               end else if (last) begin
                  // Packet ended on an id word: truncated, nothing written.
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  id_nxt    = bus.cfg_data[9:0];
                  skip_nxt  = (bus.cfg_data[9:0] == RSVD_ID);
                  if (bus.cfg_data[9:0] == RSVD_ID) begin
                     err_nxt = 1'b1;
                  end
                  state_nxt = LOAD_MASK;
               end
            end
         end

         LOAD_MASK: begin
            if (xfer) begin
               if (!skip) begin
                  wr_en_nxt   = 1'b1;
                  wr_addr_nxt = cnt_r[AW-1:0];
                  wr_data_nxt = pack_entry(bus.cfg_data[CN-1:0], pend_id);
                  cnt_nxt     = cnt_r + (AW+1)'(1);
               end
               if (last) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = LOAD_ID;
               end
            end
         end

         CLEAR: begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = clr_addr;
            wr_data_nxt = pack_entry('0, RSVD_ID);
            if (clr_addr == LAST_ADDR) begin
               done_nxt  = 1'b1;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               clr_nxt = clr_addr + AW'(1);
            end
         end

         DRAIN: begin
            if (xfer && last) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Control state and registered outputs; reset aborts any packet or sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wr_en_r   <= 1'b0;
         wr_addr_r <= '0;
         wr_data_r <= '0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         cnt_r     <= '0;
         clr_addr  <= '0;
         skip      <= 1'b0;
      end else begin
         state     <= state_nxt;
         wr_en_r   <= wr_en_nxt;
         wr_addr_r <= wr_addr_nxt;
         wr_data_r <= wr_data_nxt;
         done_r    <= done_nxt;
         err_r     <= err_nxt;
         cnt_r     <= cnt_nxt;
         clr_addr  <= clr_nxt;
         skip      <= skip_nxt;
      end
   end

   // Pending stream_id is pure data and only meaningful after an id word.
   always_ff @(posedge clk) begin
      pend_id <= id_nxt;
   end
endmodule

// File: tb/tb_cast_rt_loader.sv
// Bench for cast_rt_loader: directed packets plus randomized packets with
// random valid gaps, checked against a packet-level reference model.
module tb_cast_rt_loader;
   localparam int CN    = 5;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);
   localparam int EW    = 10 + CN;

   logic clk;
   logic rst;

   cast_rt_loader_if #(.CN(CN), .DEPTH(DEPTH)) bus ();

   cast_rt_loader #(.CN(CN), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [AW+EW-1:0] got_wr[$];
   logic [AW+EW-1:0] exp_wr[$];
   int               got_done = 0;
   int               exp_done = 0;
   int               m_cnt    = 0;
   logic             m_err    = 1'b0;

   logic [15:0] pkt_d[$];
   logic        pkt_l[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Capture every write and done pulse seen on the table port.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.wr_en) got_wr.push_back({bus.wr_addr, bus.wr_data});
         if (bus.done)  got_done++;
      end
   end

   // Reference: interpret a whole packet at once.
   task automatic model_pkt();
      int         n;
      int         i;
      logic [3:0] op;
      logic [9:0] id;
      logic [CN-1:0] mask;
      n  = pkt_d.size();
      op = pkt_d[0][15:12];
      exp_wr.delete();
      exp_done = 0;
      if (op == 4'hA) begin
         m_err = 1'b0;
         m_cnt = 0;
         if (n == 1) exp_done = 1;
         i = 1;
         while (i < n) begin
            if (m_cnt == DEPTH) begin m_err = 1'b1; break; end
            if (i == n - 1)     begin m_err = 1'b1; break; end
            id   = pkt_d[i][9:0];
            mask = pkt_d[i+1][CN-1:0];
            if (id == 10'h3FF) m_err = 1'b1;
            else begin
               exp_wr.push_back({AW'(m_cnt), mask, id});
               m_cnt++;
            end
            if (i + 1 == n - 1) exp_done = 1;
            i += 2;
         end
      end else if (op == 4'hC) begin
         m_err    = 1'b0;
         m_cnt    = 0;
         exp_done = 1;
         for (int a = 0; a < DEPTH; a++) exp_wr.push_back({AW'(a), {CN{1'b0}}, 10'h3FF});
      end else begin
         m_err = 1'b1;
      end
   endtask

   task automatic add_word(input logic [15:0] d, input logic l);
      pkt_d.push_back(d);
      pkt_l.push_back(l);
   endtask

   // Present one word with random idle gaps; returns at the negedge after acceptance.
   task automatic send_word(input logic [15:0] d, input logic l);
      int gaps;
      int budget;
      gaps   = $urandom_range(0, 2);
      budget = 0;
      repeat (gaps) begin
         bus.cfg_valid = 1'b0;
         bus.cfg_data  = 16'($urandom);
         bus.cfg_last  = 1'($urandom);
         @(negedge clk);
      end
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = d;
      bus.cfg_last  = l;
      while (!bus.cfg_ready) begin
         @(negedge clk);
         budget++;
         if (budget > 200) begin
            $display("FAIL ready_timeout got=0 exp=1");
            $fatal(1, "cfg_ready never returned");
         end
      end
      @(posedge clk);
      #1;
      bus.cfg_valid = 1'b0;
      bus.cfg_data  = 16'($urandom);
      bus.cfg_last  = 1'($urandom);
      @(negedge clk);
   endtask

   task automatic finish_pkt(input string tag);
      int budget;
      budget = 0;
      while (bus.busy && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
      @(negedge clk);
      model_pkt();
      chk({tag, "_nwr"}, 64'(got_wr.size()), 64'(exp_wr.size()));
      for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
         chk({tag, "_wr"}, 64'(got_wr[i]), 64'(exp_wr[i]));
      chk({tag, "_done"}, 64'(got_done), 64'(exp_done));
      chk({tag, "_err"}, 64'(bus.err), 64'(m_err));
      chk({tag, "_cnt"}, 64'(bus.entry_count), 64'(m_cnt));
   endtask

   task automatic send_pkt(input string tag);
      got_wr.delete();
      got_done = 0;
      for (int i = 0; i < pkt_d.size(); i++) begin
         send_word(pkt_d[i], pkt_l[i]);
         if (i < pkt_d.size() - 1) chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
      end
      finish_pkt(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_wr_en"},   64'(bus.wr_en),       64'd0);
      chk({tag, "_wr_addr"}, 64'(bus.wr_addr),     64'd0);
      chk({tag, "_wr_data"}, 64'(bus.wr_data),     64'd0);
      chk({tag, "_done"},    64'(bus.done),        64'd0);
      chk({tag, "_err"},     64'(bus.err),         64'd0);
      chk({tag, "_cnt"},     64'(bus.entry_count), 64'd0);
      chk({tag, "_busy"},    64'(bus.busy),        64'd0);
      chk({tag, "_ready"},   64'(bus.cfg_ready),   64'd0);
   endtask

   task automatic build_random();
      int         kind;
      int         k;
      logic [3:0] op;
      logic [9:0] id;
      logic       trunc;
      pkt_d.delete();
      pkt_l.delete();
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
         k     = ($urandom_range(0, 6) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 4);
         trunc = (k > 0) && ($urandom_range(0, 6) == 0);
         add_word({4'hA, 12'($urandom)}, 1'b0);
         for (int e = 0; e < k; e++) begin
            id = ($urandom_range(0, 5) == 0) ? 10'h3FF : 10'($urandom);
            add_word({6'($urandom), id}, 1'b0);
            if (!(trunc && e == k - 1)) add_word(16'($urandom), 1'b0);
         end
      end else if (kind <= 7) begin
         add_word({4'hC, 12'($urandom)}, 1'($urandom));
      end else begin
         op = 4'($urandom);
         while (op == 4'hA || op == 4'hC) op = 4'($urandom);
         add_word({op, 12'($urandom)}, 1'b0);
         k = $urandom_range(0, 3);
         for (int e = 0; e < k; e++) add_word(16'($urandom), 1'b0);
      end
      pkt_l[pkt_l.size() - 1] = 1'b1;
      if (pkt_d[0][15:12] == 4'hC) pkt_l[0] = 1'($urandom);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lowcnt;
      rst           = 1'b1;
      bus.cfg_valid = 1'b0;
      bus.cfg_data  = '0;
      bus.cfg_last  = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst0");
      rst = 1'b0;
      @(negedge clk);
      chk("rel_ready", 64'(bus.cfg_ready), 64'd1);

      // Two-entry load.
      pkt_d.delete(); pkt_l.delete();
      add_word(16'hA000, 1'b0);
      add_word(16'h0005, 1'b0);
      add_word(16'h0003, 1'b0);
      add_word(16'h012C, 1'b0);
      add_word(16'h0014, 1'b1);
      send_pkt("load2");
      chk("load2_cnt_const", 64'(bus.entry_count), 64'd2);

      // Clear sweep, counting cycles with cfg_ready low.
      pkt_d.delete(); pkt_l.delete();
      add_word(16'hC000, 1'b1);
      got_wr.delete();
      got_done = 0;
      send_word(pkt_d[0], pkt_l[0]);
      lowcnt = 0;
      while (!bus.cfg_ready && lowcnt < 100) begin
         lowcnt++;
         @(negedge clk);
      end
      chk("clear_ready_low", 64'(lowcnt), 64'(DEPTH));
      finish_pkt("clear");

      // Overflow: 17 entries into a 16-deep table.
      pkt_d.delete(); pkt_l.delete();
      add_word(16'hA000, 1'b0);
      for (int e = 0; e < 17; e++) begin
         add_word(16'(e + 1), 1'b0);
         add_word(16'(e), e == 16);
      end
      send_pkt("ovf");
      chk("ovf_err_const", 64'(bus.err), 64'd1);
      pkt_d.delete(); pkt_l.delete();
      add_word(16'hA000, 1'b1);
      send_pkt("hdr_clr_err");

      // Illegal opcode followed by three words.
      pkt_d.delete(); pkt_l.delete();
      add_word(16'h3000, 1'b0);
      add_word(16'h1234, 1'b0);
      add_word(16'h5678, 1'b0);
      add_word(16'h9ABC, 1'b1);
      send_pkt("illegal");

      for (int p = 0; p < 70; p++) begin
         build_random();
         send_pkt("rnd");
      end

      // Reset after the first of three entries.
      got_wr.delete();
      got_done = 0;
      send_word(16'hA000, 1'b0);
      send_word(16'h0011, 1'b0);
      send_word(16'h0015, 1'b0);
      send_word(16'h0022, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      bus.cfg_valid = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("rst_hold");
      bus.cfg_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rel_ready", 64'(bus.cfg_ready), 64'd1);
      chk("rst_rel_busy",  64'(bus.busy),      64'd0);
      chk("rst_nwr",       64'(got_wr.size()), 64'd1);
      if (got_wr.size() > 0) chk("rst_wr0", 64'(got_wr[0]), 64'({4'd0, 5'b10101, 10'h011}));
      m_cnt = 0;
      m_err = 1'b0;

      for (int p = 0; p < 15; p++) begin
         build_random();
         send_pkt("rnd2");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
